// File: rtl/pirdsp_pkg.sv
// Shared constants and types for the PIR-DSP SIMD multiplier.
// Holds the mode encodings, default geometry and the control bundle that travels with each operand.
package pirdsp_pkg;

  localparam logic MODE_NARROW = 1'b0;
  localparam logic MODE_WIDE   = 1'b1;

  localparam int DEF_LANE_W = 9;
  localparam int DEF_LANES  = 6;

  typedef struct packed {
    logic mode;
    logic isSigned;
    logic accEn;
  } ctrl_t;

endpackage

// File: rtl/pirdsp_simd_mult_if.sv
// Operand/result bus of the SIMD multiplier.
// The valid/ready pair on each side forms an elastic handshake.
interface pirdsp_simd_mult_if
  import pirdsp_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES
);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*LANE_W-1:0]    a;
  logic [LANES*LANE_W-1:0]    b;
  logic                       mode;
  logic                       is_signed;
  logic                       acc_en;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*2*LANE_W-1:0]  y;
  logic [LANES-1:0]           ovf;

  modport master (
    output in_valid, a, b, mode, is_signed, acc_en, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, is_signed, acc_en, out_ready,
    output in_ready, out_valid, y, ovf
  );

endinterface

// File: rtl/pirdsp_simd_pair.sv
// One 2W x 2W multiplier slice: two independent W x W products or one fused 2W x 2W product.
// Products are formed at the input and then carried through DEPTH advance-gated registers.
module pirdsp_simd_pair
  import pirdsp_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_adv,
  input  logic [2*LANE_W-1:0]   i_a,
  input  logic [2*LANE_W-1:0]   i_b,
  input  logic                  i_mode,
  input  logic                  i_isSigned,
  output logic [4*LANE_W-1:0]   o_prod
);

  localparam int W = LANE_W;

  logic [2*W-1:0] w_aLoExt, w_bLoExt, w_aHiExt, w_bHiExt;
  logic [4*W-1:0] w_aWideExt, w_bWideExt;
  logic [2*W-1:0] w_loProd, w_hiProd;
  logic [4*W-1:0] w_wideProd;
  logic [4*W-1:0] w_prod;

  // Extending operands to the product width makes the truncated product exact for both signednesses.
  always_comb begin
    w_aLoExt   = {{W{i_isSigned & i_a[W-1]}}, i_a[W-1:0]};
    w_bLoExt   = {{W{i_isSigned & i_b[W-1]}}, i_b[W-1:0]};
    w_aHiExt   = {{W{i_isSigned & i_a[2*W-1]}}, i_a[2*W-1:W]};
    w_bHiExt   = {{W{i_isSigned & i_b[2*W-1]}}, i_b[2*W-1:W]};
    w_aWideExt = {{2*W{i_isSigned & i_a[2*W-1]}}, i_a};
    w_bWideExt = {{2*W{i_isSigned & i_b[2*W-1]}}, i_b};
    w_loProd   = w_aLoExt * w_bLoExt;
    w_hiProd   = w_aHiExt * w_bHiExt;
    w_wideProd = w_aWideExt * w_bWideExt;
    w_prod     = (i_mode == MODE_WIDE) ? w_wideProd : {w_hiProd, w_loProd};
  end

  if (DEPTH == 0) begin : g_noPipe
    assign o_prod = w_prod;
  end else begin : g_pipe
    logic [4*W-1:0] r_prod [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) r_prod[k] <= '0;
      end else if (i_adv) begin
        r_prod[0] <= w_prod;
        for (int k = 1; k < DEPTH; k++) r_prod[k] <= r_prod[k-1];
      end
    end

    assign o_prod = r_prod[DEPTH-1];
  end

endmodule

// File: rtl/pirdsp_simd_mult.sv
// Pipelined SIMD multiplier with run-time lane fusion, signedness select and per-lane accumulate.
// The output register doubles as the accumulator; the whole pipe moves on a single advance signal.
module pirdsp_simd_mult
  import pirdsp_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  pirdsp_simd_mult_if.slave bus
);

  localparam int W     = LANE_W;
  localparam int SW    = 2 * W;
  localparam int PAIRS = LANES / 2;
  localparam int DEPTH = STAGES - 1;

  logic                 w_adv;
  ctrl_t                w_inCtrl;
  logic                 w_lastValid;
  ctrl_t                w_lastCtrl;
  logic [LANES*SW-1:0]  w_yNext;
  logic [LANES-1:0]     w_ovfNext;

  logic                 r_outValid;
  logic [LANES*SW-1:0]  r_y;
  logic [LANES-1:0]     r_ovf;

  assign w_adv    = !r_outValid || bus.out_ready;
  assign w_inCtrl = '{mode: bus.mode, isSigned: bus.is_signed, accEn: bus.acc_en};

  if (DEPTH == 0) begin : g_noCtrlPipe
    assign w_lastValid = bus.in_valid;
    assign w_lastCtrl  = w_inCtrl;
  end else begin : g_ctrlPipe
    logic  r_vPipe [DEPTH];
    ctrl_t r_cPipe [DEPTH];

    // Valid and control bundle shadow the product registers inside each pair.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_vPipe[k] <= 1'b0;
          r_cPipe[k] <= '0;
        end
      end else if (w_adv) begin
        r_vPipe[0] <= bus.in_valid;
        r_cPipe[0] <= w_inCtrl;
        for (int k = 1; k < DEPTH; k++) begin
          r_vPipe[k] <= r_vPipe[k-1];
          r_cPipe[k] <= r_cPipe[k-1];
        end
      end
    end

    assign w_lastValid = r_vPipe[DEPTH-1];
    assign w_lastCtrl  = r_cPipe[DEPTH-1];
  end

  for (genvar j = 0; j < PAIRS; j++) begin : g_pair
    logic [2*SW-1:0] w_prod;
    logic [2*SW-1:0] w_old;
    logic [2*SW:0]   w_sumWide;
    logic [SW:0]     w_sumLo, w_sumHi;
    logic            w_ovfWide, w_ovfLo, w_ovfHi;
    logic [2*SW-1:0] w_ySlot;
    logic [1:0]      w_ovfSlot;

    pirdsp_simd_pair #(
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
    ) u_pair (
      .clk        (clk),
      .rst        (rst),
      .i_adv      (w_adv),
      .i_a        (bus.a[j*SW +: SW]),
      .i_b        (bus.b[j*SW +: SW]),
      .i_mode     (bus.mode),
      .i_isSigned (bus.is_signed),
      .o_prod     (w_prod)
    );

    assign w_old = r_y[j*2*SW +: 2*SW];

    // Previous y is reinterpreted in whatever slot layout the arriving result uses.
    always_comb begin
      w_sumWide = {1'b0, w_old} + {1'b0, w_prod};
      w_sumLo   = {1'b0, w_old[SW-1:0]} + {1'b0, w_prod[SW-1:0]};
      w_sumHi   = {1'b0, w_old[2*SW-1:SW]} + {1'b0, w_prod[2*SW-1:SW]};
      w_ovfWide = w_sumWide[2*SW];
      w_ovfLo   = w_sumLo[SW];
      w_ovfHi   = w_sumHi[SW];
      if (w_lastCtrl.isSigned) begin
        w_ovfWide = (w_old[2*SW-1] == w_prod[2*SW-1]) && (w_sumWide[2*SW-1] != w_old[2*SW-1]);
        w_ovfLo   = (w_old[SW-1] == w_prod[SW-1]) && (w_sumLo[SW-1] != w_old[SW-1]);
        w_ovfHi   = (w_old[2*SW-1] == w_prod[2*SW-1]) && (w_sumHi[SW-1] != w_old[2*SW-1]);
      end
      w_ySlot   = w_prod;
      w_ovfSlot = 2'b00;
      if (w_lastCtrl.accEn) begin
        if (w_lastCtrl.mode == MODE_WIDE) begin
          w_ySlot   = w_sumWide[2*SW-1:0];
          w_ovfSlot = {2{w_ovfWide}};
        end else begin
          w_ySlot   = {w_sumHi[SW-1:0], w_sumLo[SW-1:0]};
          w_ovfSlot = {w_ovfHi, w_ovfLo};
        end
      end
    end

    assign w_yNext[j*2*SW +: 2*SW] = w_ySlot;
    assign w_ovfNext[2*j +: 2]     = w_ovfSlot;
  end

  // Bubbles clear out_valid but leave y untouched so the next accumulate sees the last real result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_y        <= '0;
      r_ovf      <= '0;
    end else if (w_adv) begin
      r_outValid <= w_lastValid;
      if (w_lastValid) begin
        r_y   <= w_yNext;
        r_ovf <= w_ovfNext;
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_outValid;
  assign bus.y         = r_y;
  assign bus.ovf       = r_ovf;

endmodule

// File: doc/pirdsp_simd_mult.md
# pirdsp_simd_mult

Parametrised, pipelined SIMD multiplier for the PIR-DSP datapath. It is the successor of the fixed six-lane 9x9 split multiplier. It adds run-time lane fusion (narrow W×W or wide 2W×2W lanes), signed/unsigned selection, per-lane accumulate with overflow flags, and a valid/ready elastic pipeline. It sits between the operand-routing stage and the post-adder/ALU of the DSP slice, and is the target of the multi-multiply techmap.

## Interface
- LANE_W, 9, narrow lane operand width W
- LANES, 6, narrow lane count; must be even, ≥2
- STAGES, 2, pipeline register stages (≥1) from input acceptance to output
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand transaction present
- in_ready  out  1  block accepts transaction this cycle
- a, b  in  LANES*LANE_W  packed operands; narrow lane i at [i*W +: W]
- mode  in  1  0 = narrow (LANES lanes of W×W), 1 = wide (LANES/2 lanes of 2W×2W)
- is_signed  in  1  1 = two's-complement operands and products
- acc_en  in  1  1 = add product into previous output value
- out_valid  out  1  y/ovf hold a result
- out_ready  in  1  downstream accepts result
- y  out  LANES*2*LANE_W  packed results; narrow lane i at [i*2W +: 2W], wide pair j at [2j*2W +: 4W]
- ovf  out  LANES  per-narrow-lane accumulate overflow; in wide mode both bits of a pair are equal

## Operation
- A transaction is captured when in_valid && in_ready. mode, is_signed and acc_en travel with the operands through every stage.
- Narrow mode: y lane i = a[i] × b[i], with W-bit operands and a 2W-bit product. Operands are sign-extended when is_signed=1, else zero-extended.
- Wide mode: pair j takes operands a[2j*W +: 2W] and b[2j*W +: 2W] and produces a 4W-bit product. No narrow-lane cross terms appear in y.
- Accumulate happens at the output register, so y doubles as the accumulator:
  - acc_en=0: y slot ← product; ovf ← 0.
  - acc_en=1: y slot ← y slot + product, wrapping modulo the slot width (2W narrow, 4W wide).
  - ovf bit ← 1 iff the true sum is not representable in the slot width, under the transaction's signedness. Unsigned overflow is carry-out. Signed overflow is operand signs equal and result sign different.
- A mode change with acc_en=1 reinterprets the previous y bits in the new slot layout. This is defined behaviour, not an error.
- ovf is per-transaction, not sticky.

## Timing
- Reset values: in_ready=1 once rst is deasserted; out_valid=0, y=0, ovf=0, all internal stage valids 0.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. All stages and the output register move only when adv=1.
- Latency is exactly STAGES cycles from acceptance to out_valid, with no stalls. Throughput is 1 transaction/cycle.
- When out_valid && !out_ready, y, ovf and out_valid hold stable, and no accumulate update occurs.
- Bubbles (invalid stage slots) propagate and do not touch y. Accumulation uses the last delivered y, regardless of bubbles in between.
- A simultaneous result consumed and new result arriving in the same cycle is legal; y updates with no gap.
- rst asserted mid-stream discards all in-flight transactions immediately (asynchronous). The first result after reset with acc_en=1 accumulates onto 0.

## Structure
- Package pirdsp_pkg holds:
  - the mode constants: MODE_NARROW = 1'b0, MODE_WIDE = 1'b1
  - the default LANE_W and LANES
  - a typedef for the per-transaction control bundle {mode, is_signed, acc_en}
- Sub-module pirdsp_simd_pair, instantiated LANES/2 times: one 2W×2W signed/unsigned multiplier that produces either two independent 2W-bit narrow products or one 4W-bit wide product. It includes the pipeline registers.
- The top level holds the valid/advance logic, the output accumulator registers and the ovf logic.

## Test plan
- Reset and latency: W=9, STAGES=2, narrow unsigned, a lane0=3, b lane0=5, out_ready=1. Response: out_valid rises exactly 2 cycles after acceptance, y[17:0]=18'h0000F, all other lanes 0, ovf=0.
- Signed and unsigned narrow:
  - Signed, a lane0=9'h100, b lane0=9'h100 (−256×−256): y[17:0]=18'h10000.
  - Unsigned, lane1 a=b=9'h1FF: y[35:18]=18'h3FC01.
- Wide mode, unsigned, pair0 a=b=18'h1FFFF: y[35:0]=36'h3FFFC0001, ovf[1:0]=0.
- Accumulate overflow, signed narrow, lane0 −256×−256 twice:
  - First transaction acc_en=0: y=18'h10000, ovf[0]=0.
  - Second transaction acc_en=1: y=18'h20000 (wrapped), ovf[0]=1.
- Backpressure: stream 4 transactions with out_ready=0 for 3 cycles. Response: in_ready=0 while out_valid && !out_ready, y held stable, all 4 results emerge in order with no loss or duplication.
- Mid-stream reset: assert rst with 2 transactions in flight. Response: out_valid=0 and y=0 immediately; after release, nothing stale emerges.
